// File: rtl/subvec_assembler.sv
// subvec_assembler: rebuilds padded vectors from BUS_WIDTH beats and hands vector+popcount downstream.
// Optional SUBVEC_ASSEMBLER_POPCNT_CHECK_EN adds a running popcount cross-check driving o_Err[1].
module subvec_assembler #(
    parameter int BUS_WIDTH = 128,
    parameter int VECTOR_WIDTH = 920,
    localparam int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
    localparam int OUTPUT_VECTOR_WIDTH = BUS_WIDTH * SUB_VECTOR_NO,
    localparam int CNT_WIDTH = $clog2(OUTPUT_VECTOR_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [BUS_WIDTH-1:0]           i_SubVector,
    input  logic                           i_Valid,
    output logic                           o_Ready,
    input  logic [CNT_WIDTH-1:0]           i_Cnt,
    input  logic                           i_CntNew,
    output logic [OUTPUT_VECTOR_WIDTH-1:0] o_Vector,
    output logic [CNT_WIDTH-1:0]           o_Cnt,
    output logic                           o_Valid,
    input  logic                           i_Ready,
    output logic [1:0]                     o_Err
);
    localparam int BI = SUB_VECTOR_NO > 1 ? $clog2(SUB_VECTOR_NO) : 1;

    logic [BI-1:0]                  beat_q, beat_d;
    logic                           seen_q, seen_d, valid_q, valid_d;
    logic [CNT_WIDTH-1:0]           lcnt_q, lcnt_d, ocnt_q, ocnt_d, cap_cnt;
    logic [OUTPUT_VECTOR_WIDTH-1:0] asm_q, asm_d, vec_q, vec_d;
    logic [1:0]                     err_q, err_d;
    logic                           last, in_xfer, fin, cap_seen, mismatch;

    assign last     = beat_q == BI'(SUB_VECTOR_NO - 1);
    assign o_Ready  = !(last && valid_q && !i_Ready);
    assign in_xfer  = i_Valid && o_Ready;
    assign fin      = in_xfer && last;
    // A count arriving on the final beat itself wins over the latched one
    assign cap_seen = i_CntNew || seen_q;
    assign cap_cnt  = i_CntNew ? i_Cnt : lcnt_q;

`ifdef SUBVEC_ASSEMBLER_POPCNT_CHECK_EN
    logic [CNT_WIDTH:0] acc_q, acc_d, beat_pop;
    always_comb begin
        beat_pop = '0;
        for (int j = 0; j < BUS_WIDTH; j++)
            if (int'(beat_q) * BUS_WIDTH + j < VECTOR_WIDTH)
                beat_pop = beat_pop + (CNT_WIDTH+1)'(i_SubVector[j]);
        acc_d    = in_xfer ? (last ? '0 : acc_q + beat_pop) : acc_q;
        mismatch = !cap_seen || (acc_q + beat_pop) != {1'b0, cap_cnt};
    end
    always_ff @(posedge clk)
        acc_q <= !rstn ? '0 : acc_d;
`else
    assign mismatch = 1'b0;
`endif

    always_comb begin
        beat_d  = beat_q;
        asm_d   = asm_q;
        seen_d  = seen_q;
        lcnt_d  = lcnt_q;
        vec_d   = vec_q;
        ocnt_d  = ocnt_q;
        valid_d = valid_q && !i_Ready;
        err_d   = err_q;
        if (in_xfer) begin
            asm_d[int'(beat_q) * BUS_WIDTH +: BUS_WIDTH] = i_SubVector;
            beat_d = last ? '0 : beat_q + 1'b1;
            seen_d = !last && cap_seen;
            lcnt_d = last ? '0 : cap_cnt;
        end
        if (fin) begin
            vec_d   = asm_d;
            ocnt_d  = cap_seen ? cap_cnt : '0;
            valid_d = 1'b1;
            err_d   = err_q | {mismatch, !cap_seen};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_q  <= '0;
            asm_q   <= '0;
            seen_q  <= 1'b0;
            lcnt_q  <= '0;
            vec_q   <= '0;
            ocnt_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            seen_q  <= seen_d;
            lcnt_q  <= lcnt_d;
            vec_q   <= vec_d;
            ocnt_q  <= ocnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_Vector = vec_q;
    assign o_Cnt    = ocnt_q;
    assign o_Valid  = valid_q;
    assign o_Err    = err_q;
endmodule
